// File: rtl/digit_counter_pkg.sv
// Shared types for the digit counter feeding the seven-segment decoder.
// Holds FSM encoding and the counter width.
package digit_counter_pkg;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int COUNT_W = 8;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for a push-button.
// The pulse is gated by ena so edges arriving while disabled are lost.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // History keeps tracking while disabled so a held button never
    // produces a late pulse once ena returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = ena & s2 & ~s3;

endmodule

// File: rtl/digit_counter.sv
// Prescaled / single-step bounded up-down counter for the segment decoder.
// Count stays inside 0..MAX_VALUE; tick and wrap are registered pulses.
module digit_counter
    import digit_counter_pkg::*;
#(
    parameter int DIV       = 10_000_000,
    parameter int DIV_WIDTH = 24,
    parameter int MAX_VALUE = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               run,
    input  logic               up_dn,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_value,
    input  logic               step,
    output logic [COUNT_W-1:0] counter,
    output logic               tick,
    output logic               wrap,
    output logic               running
);

    localparam logic [COUNT_W-1:0]   MAXV = COUNT_W'(MAX_VALUE);
    localparam logic [DIV_WIDTH-1:0] PTOP = DIV_WIDTH'(DIV - 1);

    state_t               state;
    state_t               state_nx;
    logic [DIV_WIDTH-1:0] presc;
    logic                 presc_top;
    logic                 step_rise;
    logic                 adv;
    logic                 load_en;
    logic [COUNT_W-1:0]   ld_val;
    logic [COUNT_W-1:0]   cnt_nx;
    logic                 wrap_nx;

    btn_sync_edge u_step (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .btn   (step),
        .rise  (step_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_STOP;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (ena) begin
            state_nx = run ? ST_RUN : ST_STOP;
        end
    end

    assign running   = (state == ST_RUN);
    assign presc_top = (presc == PTOP);
    assign load_en   = ena & load;
    assign adv       = ena & (running ? presc_top : step_rise);
    assign ld_val    = (load_value > MAXV) ? MAXV : load_value;

    // Explicit bound compare before +/-1 keeps the count in range.
    always_comb begin
        cnt_nx  = counter;
        wrap_nx = 1'b0;
        if (up_dn) begin
            if (counter >= MAXV) begin
                cnt_nx  = '0;
                wrap_nx = 1'b1;
            end else begin
                cnt_nx = counter + COUNT_W'(1);
            end
        end else begin
            if (counter == '0) begin
                cnt_nx  = MAXV;
                wrap_nx = 1'b1;
            end else begin
                cnt_nx = counter - COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (ena) begin
            if (load || (state_nx != state) || !running) begin
                presc <= '0;
            end else if (presc_top) begin
                presc <= '0;
            end else begin
                presc <= presc + DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else if (load_en) begin
            counter <= ld_val;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else if (adv) begin
            counter <= cnt_nx;
            tick    <= 1'b1;
            wrap    <= wrap_nx;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_digit_counter.sv
// Bench for digit_counter: behavioural model plus directed literal checks.
// Random phase exercises run/step/load/ena/reset interplay.
module tb_digit_counter;

    localparam int DIV  = 4;
    localparam int MAXV = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       run = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'd0;
    logic       step = 1'b0;
    logic [7:0] counter;
    logic       tick;
    logic       wrap;
    logic       running;

    int n_checks = 0;
    int n_fail = 0;

    int m_cnt;
    int m_ph;
    bit m_run;
    bit m_tick;
    bit m_wrap;
    bit smp [1:3];

    int ticks;
    int wraps;
    int hold;

    digit_counter #(
        .DIV       (DIV),
        .DIV_WIDTH (8),
        .MAX_VALUE (MAXV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .run        (run),
        .up_dn      (up_dn),
        .load       (load),
        .load_value (load_value),
        .step       (step),
        .counter    (counter),
        .tick       (tick),
        .wrap       (wrap),
        .running    (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_cnt  = 0;
        m_ph   = 0;
        m_run  = 0;
        m_tick = 0;
        m_wrap = 0;
        smp[1] = 0;
        smp[2] = 0;
        smp[3] = 0;
    endtask

    // Model of one clock edge from the rules: the step pin reaches the
    // edge detector two samples late, the prescaler is a phase count.
    task automatic m_step();
        bit rise;
        bit adv;
        bit nrun;
        if (!rst_n) begin
            m_reset();
            return;
        end
        rise = ena && smp[2] && !smp[3];
        m_tick = 0;
        m_wrap = 0;
        if (ena) begin
            adv  = m_run ? ((m_ph % DIV) == DIV - 1) : rise;
            nrun = run;
            if (load) begin
                m_cnt = (int'(load_value) > MAXV) ? MAXV : int'(load_value);
            end else if (adv) begin
                m_tick = 1;
                if (up_dn) begin
                    m_wrap = (m_cnt == MAXV);
                    m_cnt  = (m_cnt + 1) % (MAXV + 1);
                end else begin
                    m_wrap = (m_cnt == 0);
                    m_cnt  = (m_cnt + MAXV) % (MAXV + 1);
                end
            end
            if (load || nrun != m_run || !m_run) m_ph = 0;
            else m_ph++;
            m_run = nrun;
        end
        smp[3] = smp[2];
        smp[2] = smp[1];
        smp[1] = step;
    endtask

    task automatic compare();
        check("counter", int'(counter), m_cnt);
        check("tick", int'(tick), int'(m_tick));
        check("wrap", int'(wrap), int'(m_wrap));
        check("running", int'(running), int'(m_run));
    endtask

    task automatic cyc();
        @(posedge clk);
        m_step();
        #1;
        compare();
        ticks += int'(tick);
        wraps += int'(wrap);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        #1;
        compare();
    endtask

    initial begin
        m_reset();
        ticks = 0;
        wraps = 0;

        // Reset held with run=1
        run = 1'b1;
        do_reset();
        cycles(5);
        check("rst_counter", int'(counter), 0);
        check("rst_running", int'(running), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_wrap", int'(wrap), 0);
        rst_n = 1'b1;
        cyc();
        check("run_entry", int'(running), 1);
        cycles(3);
        check("pre_first_tick", int'(tick), 0);
        cyc();
        check("first_tick", int'(tick), 1);
        check("first_count", int'(counter), 1);

        // Up-wrap over remaining 36 cycles
        ticks = 1;
        wraps = 0;
        cycles(36);
        check("up_ticks", ticks, 10);
        check("up_wraps", wraps, 1);
        check("up_wrap_value", int'(counter), 0);

        // Clamped load then count down through wrap
        load = 1'b1;
        load_value = 8'd200;
        cyc();
        load = 1'b0;
        check("clamp_value", int'(counter), 9);
        check("clamp_tick", int'(tick), 0);
        up_dn = 1'b0;
        ticks = 0;
        wraps = 0;
        cycles(40);
        check("dn_ticks", ticks, 10);
        check("dn_wraps", wraps, 1);
        check("dn_value", int'(counter), 9);

        // Step mode
        run = 1'b0;
        up_dn = 1'b1;
        cycles(3);
        load = 1'b1;
        load_value = 8'd0;
        cyc();
        load = 1'b0;
        cycles(5);
        ticks = 0;
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            for (int i = 0; i < 10; i++) begin
                cyc();
                if (i == 1) check("step_early", int'(counter), k);
                if (i == 2) begin
                    check("step_value", int'(counter), k + 1);
                    check("step_tick", int'(tick), 1);
                end
            end
            step = 1'b0;
            cycles(10);
        end
        check("step_ticks", ticks, 3);

        // Step ignored while running
        run = 1'b1;
        cycles(2);
        step = 1'b1;
        cycles(10);
        step = 1'b0;
        cycles(6);

        // Load coincident with a prescaler advance
        for (int i = 0; i < 8 && (m_ph % DIV) != DIV - 1; i++) cyc();
        check("sim_phase", m_ph % DIV, DIV - 1);
        load = 1'b1;
        load_value = 8'd5;
        cyc();
        load = 1'b0;
        check("sim_load", int'(counter), 5);
        check("sim_tick", int'(tick), 0);
        cycles(3);
        check("sim_hold", int'(tick), 0);
        cyc();
        check("sim_next", int'(counter), 6);
        check("sim_next_tick", int'(tick), 1);

        // Enable gating with a step pulse in the window
        cycles(2);
        hold = m_cnt;
        ena = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step = (i >= 3 && i < 13);
            cyc();
            check("ena_hold", int'(counter), hold);
            check("ena_tick", int'(tick), 0);
            check("ena_run", int'(running), 1);
        end
        step = 1'b0;
        ena = 1'b1;
        cycles(12);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                cyc();
                rst_n = 1'b1;
            end
            ena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) run = ~run;
            if ($urandom_range(0, 29) == 0) up_dn = ~up_dn;
            load = ($urandom_range(0, 49) == 0);
            load_value = ($urandom_range(0, 1) != 0) ?
                8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) step = ~step;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
